// File: rtl/coherence_bus_ctrl_if.sv
// Cache/RAM-side signal bundle of the snooping bus controller.
// master: the controller; slave: the caches and memory it serves.
interface coherence_bus_ctrl_if #(
    parameter int CPUS   = 2,
    parameter int WORD_W = 32
) ();
    logic [CPUS-1:0]             dREN;
    logic [CPUS-1:0]             dWEN;
    logic [CPUS-1:0]             cctrans;
    logic [CPUS-1:0]             ccwrite;
    logic [CPUS-1:0][31:0]       daddr;
    logic [CPUS-1:0][WORD_W-1:0] dstore;
    logic [CPUS-1:0]             dwait;
    logic [CPUS-1:0][WORD_W-1:0] dload;
    logic [CPUS-1:0]             ccwait;
    logic [CPUS-1:0]             ccinv;
    logic [CPUS-1:0][31:0]       ccsnoopaddr;
    logic                        ramREN;
    logic                        ramWEN;
    logic [31:0]                 ramaddr;
    logic [WORD_W-1:0]           ramstore;
    logic [WORD_W-1:0]           ramload;
    logic                        ramwait;

    modport master (
        input  dREN, dWEN, cctrans, ccwrite, daddr, dstore, ramload, ramwait,
        output dwait, dload, ccwait, ccinv, ccsnoopaddr, ramREN, ramWEN, ramaddr, ramstore
    );

    modport slave (
        output dREN, dWEN, cctrans, ccwrite, daddr, dstore, ramload, ramwait,
        input  dwait, dload, ccwait, ccinv, ccsnoopaddr, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/coherence_bus_ctrl.sv
// Snooping bus controller: round-robin grant, one snoop cycle, then cache-to-cache or RAM block transfer.
// Latency: grant +1 snoop +1 first RAM word (writeback: grant +1); every RAM word stalls while ramwait is high.
module coherence_bus_ctrl #(
    parameter int CPUS        = 2,
    parameter int WORD_W      = 32,
    parameter int BLOCK_WORDS = 2
) (
    input  logic                 CLK,
    input  logic                 nRST,
    coherence_bus_ctrl_if.master bus
);
    localparam int IW = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam int WW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

    typedef enum logic [2:0] {IDLE, SNOOP, XFER, MEMRD, WB, INV} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] req_q, req_d;
    logic [IW-1:0] resp_q, resp_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [WW-1:0] wcnt_q, wcnt_d;

    logic [IW-1:0] rr_next;
    logic [IW-1:0] grant_idx;
    logic          grant_vld;
    logic [IW-1:0] resp_idx;
    logic          resp_vld;
    logic          last_word;
    logic          data_phase;
    logic [CPUS-1:0] requesting;

    logic [CPUS-1:0]             dwait;
    logic [CPUS-1:0]             ccwait;
    logic [CPUS-1:0]             ccinv;
    logic [CPUS-1:0][WORD_W-1:0] dload;
    logic [CPUS-1:0][31:0]       snoop_addr;
    logic                        ram_ren;
    logic                        ram_wen;
    logic [31:0]                 ram_addr;
    logic [WORD_W-1:0]           ram_store;

    assign requesting = bus.dREN | bus.dWEN | bus.cctrans;
    assign rr_next    = (int'(req_q) == CPUS - 1) ? '0 : req_q + 1'b1;
    assign last_word  = (int'(wcnt_q) == BLOCK_WORDS - 1);
    assign data_phase = (state_q == XFER) || (state_q == MEMRD) || (state_q == WB);

    // First requester at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < CPUS; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= CPUS) begin
                idx = idx - CPUS;
            end
            if (!grant_vld && requesting[IW'(idx)]) begin
                grant_vld = 1'b1;
                grant_idx = IW'(idx);
            end
        end
    end

    // Lowest-indexed other cache claiming the block modified; descending scan lets the lowest win.
    always_comb begin
        resp_vld = 1'b0;
        resp_idx = '0;
        for (int i = CPUS - 1; i >= 0; i--) begin
            if (i != int'(req_q) && bus.ccwrite[i]) begin
                resp_vld = 1'b1;
                resp_idx = IW'(i);
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            req_q    <= '0;
            resp_q   <= '0;
            wcnt_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            resp_q   <= resp_d;
            wcnt_q   <= wcnt_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        resp_d     = resp_q;
        wcnt_d     = wcnt_q;
        rr_ptr_d   = rr_ptr_q;
        dwait      = '1;
        ccwait     = '0;
        ccinv      = '0;
        dload      = '0;
        snoop_addr = '0;
        ram_ren    = 1'b0;
        ram_wen    = 1'b0;
        ram_addr   = '0;
        ram_store  = '0;

        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    req_d = grant_idx;
                    if (bus.dWEN[grant_idx]) begin
                        state_d = WB;
                    end else if (bus.dREN[grant_idx]) begin
                        state_d = SNOOP;
                    end else begin
                        state_d = INV;
                    end
                end
            end
            SNOOP: begin
                for (int i = 0; i < CPUS; i++) begin
                    if (i != int'(req_q)) begin
                        ccwait[i]     = 1'b1;
                        ccinv[i]      = bus.cctrans[req_q];
                        snoop_addr[i] = bus.daddr[req_q];
                    end
                end
                if (resp_vld) begin
                    resp_d  = resp_idx;
                    state_d = XFER;
                end else begin
                    state_d = MEMRD;
                end
            end
            XFER: begin
                // The memory copy is refreshed while the dirty block is forwarded.
                for (int i = 0; i < CPUS; i++) begin
                    if (i != int'(req_q)) begin
                        ccwait[i] = 1'b1;
                    end
                end
                ram_wen        = 1'b1;
                ram_addr       = bus.daddr[req_q];
                ram_store      = bus.dstore[resp_q];
                dload[req_q]   = bus.dstore[resp_q];
                dwait[req_q]   = bus.ramwait;
                dwait[resp_q]  = bus.ramwait;
            end
            MEMRD: begin
                ram_ren      = 1'b1;
                ram_addr     = bus.daddr[req_q];
                dload[req_q] = bus.ramload;
                dwait[req_q] = bus.ramwait;
            end
            WB: begin
                ram_wen      = 1'b1;
                ram_addr     = bus.daddr[req_q];
                ram_store    = bus.dstore[req_q];
                dwait[req_q] = bus.ramwait;
            end
            INV: begin
                for (int i = 0; i < CPUS; i++) begin
                    if (i != int'(req_q)) begin
                        ccwait[i]     = 1'b1;
                        ccinv[i]      = 1'b1;
                        snoop_addr[i] = bus.daddr[req_q];
                    end
                end
                dwait[req_q] = 1'b0;
                state_d      = IDLE;
                rr_ptr_d     = rr_next;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (data_phase && !bus.ramwait) begin
            if (last_word) begin
                wcnt_d   = '0;
                state_d  = IDLE;
                rr_ptr_d = rr_next;
            end else begin
                wcnt_d = wcnt_q + 1'b1;
            end
        end
    end

    assign bus.dwait       = dwait;
    assign bus.dload       = dload;
    assign bus.ccwait      = ccwait;
    assign bus.ccinv       = ccinv;
    assign bus.ccsnoopaddr = snoop_addr;
    assign bus.ramREN      = ram_ren;
    assign bus.ramWEN      = ram_wen;
    assign bus.ramaddr     = ram_addr;
    assign bus.ramstore    = ram_store;

    a_ram_excl: assert property (@(posedge CLK) disable iff (!nRST) !(ram_ren && ram_wen));
    a_snoop_one: assert property (@(posedge CLK) disable iff (!nRST) (state_q == SNOOP) |=> (state_q != SNOOP));
    a_inv_one: assert property (@(posedge CLK) disable iff (!nRST) (state_q == INV) |=> (state_q == IDLE));
endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Scoreboard bench for coherence_bus_ctrl: every non-idle output cycle is popped and compared against
// hand-built expected records pushed by the directed stimulus.
module tb_coherence_bus_ctrl;
    localparam int          CPUS        = 2;
    localparam int          WORD_W      = 32;
    localparam int          BLOCK_WORDS = 2;
    localparam logic [31:0] K           = 32'h5A5A_0000;

    typedef struct packed {
        logic [1:0]       dwait;
        logic [1:0]       ccwait;
        logic [1:0]       ccinv;
        logic             ren;
        logic             wen;
        logic [31:0]      raddr;
        logic [31:0]      rstore;
        logic [1:0][31:0] dload;
        logic [1:0][31:0] snoop;
    } obs_t;

    logic CLK = 1'b0;
    logic nRST;

    coherence_bus_ctrl_if #(.CPUS(CPUS), .WORD_W(WORD_W)) bus ();

    coherence_bus_ctrl #(.CPUS(CPUS), .WORD_W(WORD_W), .BLOCK_WORDS(BLOCK_WORDS)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    // RAM read data is a fixed function of the address so read words are predictable.
    assign bus.ramload = bus.ramaddr ^ K;

    obs_t       sb_q[$];
    string      tag_q[$];
    int         checks    = 0;
    int         failures  = 0;
    int         stall_cfg = 0;
    int         stall_ctr = 0;
    logic [1:0] done_v;

    function automatic obs_t snap();
        obs_t s;
        s.dwait  = bus.dwait;
        s.ccwait = bus.ccwait;
        s.ccinv  = bus.ccinv;
        s.ren    = bus.ramREN;
        s.wen    = bus.ramWEN;
        s.raddr  = bus.ramaddr;
        s.rstore = bus.ramstore;
        s.dload  = bus.dload;
        s.snoop  = bus.ccsnoopaddr;
        return s;
    endfunction

    function automatic obs_t o_idle();
        obs_t o;
        o       = '0;
        o.dwait = 2'b11;
        return o;
    endfunction

    function automatic obs_t o_snoop(input int r, input logic [31:0] a, input logic inv);
        obs_t o;
        int   x;
        x          = 1 - r;
        o          = o_idle();
        o.ccwait[x] = 1'b1;
        o.ccinv[x]  = inv;
        o.snoop[x]  = a;
        return o;
    endfunction

    function automatic obs_t o_mem(input int r, input logic [31:0] a);
        obs_t o;
        o          = o_idle();
        o.ren      = 1'b1;
        o.raddr    = a;
        o.dload[r] = a ^ K;
        o.dwait[r] = 1'b0;
        return o;
    endfunction

    function automatic obs_t o_xfer(input int r, input logic [31:0] a, input logic [31:0] d);
        obs_t o;
        o           = o_idle();
        o.wen       = 1'b1;
        o.raddr     = a;
        o.rstore    = d;
        o.dload[r]  = d;
        o.dwait     = 2'b00;
        o.ccwait[1 - r] = 1'b1;
        return o;
    endfunction

    function automatic obs_t o_wb(input int r, input logic [31:0] a, input logic [31:0] d, input logic w);
        obs_t o;
        o          = o_idle();
        o.wen      = 1'b1;
        o.raddr    = a;
        o.rstore   = d;
        o.dwait[r] = w;
        return o;
    endfunction

    function automatic obs_t o_inv(input int r, input logic [31:0] a);
        obs_t o;
        int   x;
        x           = 1 - r;
        o           = o_idle();
        o.ccwait[x] = 1'b1;
        o.ccinv[x]  = 1'b1;
        o.snoop[x]  = a;
        o.dwait[r]  = 1'b0;
        return o;
    endfunction

    task automatic expect_ev(input obs_t o, input string nm);
        sb_q.push_back(o);
        tag_q.push_back(nm);
    endtask

    task automatic drain(input string nm);
        int g;
        g = 0;
        while (sb_q.size() != 0 && g < 300) begin
            @(posedge CLK);
            g++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: %0d expected events never seen", nm, sb_q.size());
            sb_q.delete();
            tag_q.delete();
        end
        #2;
    endtask

    task automatic check_reset(input string nm);
        obs_t s;
        s = snap();
        checks++;
        if (s !== o_idle()) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, s, o_idle());
        end
    endtask

    // Monitor: any cycle whose outputs differ from the idle pattern is a DUT event.
    initial begin
        obs_t  s;
        obs_t  e;
        string nm;
        forever begin
            @(negedge CLK);
            s = snap();
            if (s !== o_idle()) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event got=%h", s);
                end else begin
                    e  = sb_q.pop_front();
                    nm = tag_q.pop_front();
                    if (s !== e) begin
                        failures++;
                        $display("FAIL %s got=%h exp=%h", nm, s, e);
                    end
                end
            end
        end
    end

    // Cache address advance on completed words, and RAM stall generator.
    initial begin
        forever begin
            @(negedge CLK);
            done_v = ~bus.dwait & (bus.dREN | bus.dWEN);
            @(posedge CLK);
            #1;
            for (int i = 0; i < CPUS; i++) begin
                if (done_v[i]) begin
                    bus.daddr[i] = bus.daddr[i] + 32'd4;
                end
            end
            if (bus.ramREN || bus.ramWEN) begin
                if (stall_ctr < stall_cfg) begin
                    bus.ramwait = 1'b1;
                    stall_ctr++;
                end else begin
                    bus.ramwait = 1'b0;
                    stall_ctr   = 0;
                end
            end else begin
                bus.ramwait = 1'b0;
                stall_ctr   = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nRST        = 1'b0;
        bus.dREN    = '0;
        bus.dWEN    = '0;
        bus.cctrans = '0;
        bus.ccwrite = '0;
        bus.daddr   = '0;
        bus.dstore  = '0;
        bus.ramwait = 1'b0;
        #3;
        check_reset("reset_initial");
        repeat (2) @(posedge CLK);
        #2 nRST = 1'b1;

        // Plain read miss, no owner: snoop then two RAM words.
        @(posedge CLK); #2;
        bus.daddr[0] = 32'h100;
        bus.dREN     = 2'b01;
        expect_ev(o_snoop(0, 32'h100, 1'b0), "rd_snoop");
        expect_ev(o_mem(0, 32'h100), "rd_word0");
        expect_ev(o_mem(0, 32'h104), "rd_word1");
        drain("rd");
        bus.dREN = '0;

        // Read-exclusive with cache 0 holding the block modified.
        @(posedge CLK); #2;
        bus.daddr[1]  = 32'h200;
        bus.dstore[0] = 32'h0000_CAFE;
        bus.dstore[1] = 32'h0000_7777;
        bus.ccwrite   = 2'b01;
        bus.cctrans   = 2'b10;
        bus.dREN      = 2'b10;
        expect_ev(o_snoop(1, 32'h200, 1'b1), "rdx_snoop");
        expect_ev(o_xfer(1, 32'h200, 32'h0000_CAFE), "rdx_xfer0");
        expect_ev(o_xfer(1, 32'h204, 32'h0000_CAFE), "rdx_xfer1");
        drain("rdx");
        bus.dREN    = '0;
        bus.cctrans = '0;
        bus.ccwrite = '0;

        // Upgrade: invalidate-only.
        @(posedge CLK); #2;
        bus.daddr[0] = 32'h300;
        bus.cctrans  = 2'b01;
        expect_ev(o_inv(0, 32'h300), "upg_inv");
        drain("upg");
        bus.cctrans = '0;

        // Writeback with three stall cycles per word.
        @(posedge CLK); #2;
        bus.daddr[1]  = 32'h400;
        bus.dstore[1] = 32'h0000_1111;
        stall_cfg     = 3;
        bus.dWEN      = 2'b10;
        for (int w = 0; w < BLOCK_WORDS; w++) begin
            for (int s = 0; s < 3; s++) begin
                expect_ev(o_wb(1, 32'h400 + 32'(4 * w), 32'h0000_1111, 1'b1), "wb_stall");
            end
            expect_ev(o_wb(1, 32'h400 + 32'(4 * w), 32'h0000_1111, 1'b0), "wb_word");
        end
        drain("wb");
        bus.dWEN  = '0;
        stall_cfg = 0;

        // Both caches reading continuously: 0, 1, 0.
        @(posedge CLK); #2;
        bus.daddr[0] = 32'h500;
        bus.daddr[1] = 32'h600;
        bus.dREN     = 2'b11;
        expect_ev(o_snoop(0, 32'h500, 1'b0), "rr_a_snoop");
        expect_ev(o_mem(0, 32'h500), "rr_a_w0");
        expect_ev(o_mem(0, 32'h504), "rr_a_w1");
        expect_ev(o_snoop(1, 32'h600, 1'b0), "rr_b_snoop");
        expect_ev(o_mem(1, 32'h600), "rr_b_w0");
        expect_ev(o_mem(1, 32'h604), "rr_b_w1");
        expect_ev(o_snoop(0, 32'h508, 1'b0), "rr_c_snoop");
        expect_ev(o_mem(0, 32'h508), "rr_c_w0");
        expect_ev(o_mem(0, 32'h50C), "rr_c_w1");
        drain("rr");
        bus.dREN = '0;

        // Reset during the second read word of cache 1.
        @(posedge CLK); #2;
        bus.daddr[1] = 32'h800;
        bus.dREN     = 2'b10;
        expect_ev(o_snoop(1, 32'h800, 1'b0), "mid_snoop");
        expect_ev(o_mem(1, 32'h800), "mid_w0");
        drain("mid");
        nRST     = 1'b0;
        bus.dREN = '0;
        #1;
        check_reset("reset_mid_xfer");
        repeat (2) @(posedge CLK);
        #2 nRST = 1'b1;

        // After reset the pointer is back at cache 0.
        @(posedge CLK); #2;
        bus.daddr[0] = 32'h900;
        bus.daddr[1] = 32'hA00;
        bus.dREN     = 2'b11;
        expect_ev(o_snoop(0, 32'h900, 1'b0), "post_rst_snoop");
        expect_ev(o_mem(0, 32'h900), "post_rst_w0");
        expect_ev(o_mem(0, 32'h904), "post_rst_w1");
        drain("post_rst");
        bus.dREN = '0;

        repeat (5) @(posedge CLK);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL leftover_events got=%0d exp=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/coherence_bus_ctrl.md
COHERENCE_BUS_CTRL -- requirements
Module: coherence_bus_ctrl

Interface
REQ-001 SHALL have parameter CPUS, default 2, number of data caches (>=1).
REQ-002 SHALL have parameter WORD_W, default 32, data word width.
REQ-003 SHALL have parameter BLOCK_WORDS, default 2, words per cache block (>=1).
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 CLK  in  1  clock; all state updates on rising edge.
REQ-006 nRST  in  1  asynchronous active-low reset.
REQ-007 dREN  in  CPUS  per-cache block read request (BusRd; BusRdX when cctrans also high).
REQ-008 dWEN  in  CPUS  per-cache writeback request.
REQ-009 cctrans  in  CPUS  per-cache exclusive intent; alone, an upgrade (invalidate-only) request.
REQ-010 ccwrite  in  CPUS  per-cache snoop response: snooped block held modified.
REQ-011 daddr  in  CPUS*32  per-cache word address; the cache advances it per word.
REQ-012 dstore  in  CPUS*WORD_W  per-cache outgoing word.
REQ-013 dwait  out  CPUS  per-cache stall; 0 marks a completed word or upgrade.
REQ-014 dload  out  CPUS*WORD_W  per-cache incoming word.
REQ-015 ccwait  out  CPUS  snoop-freeze to non-requesting caches.
REQ-016 ccinv  out  CPUS  invalidate the snooped block.
REQ-017 ccsnoopaddr  out  CPUS*32  snoop address to each cache.
REQ-018 ramREN, ramWEN  out  1 each; ramaddr  out  32; ramstore  out  WORD_W.
REQ-019 ramload  in  WORD_W; ramwait  in  1  RAM not ready this cycle.

Function
REQ-020 FSM states: IDLE, SNOOP, XFER, MEMRD, WB, INV.
REQ-021 IDLE: a cache is requesting if dREN|dWEN|cctrans is set; grant goes to the first requester at or after rr_ptr, wrapping modulo CPUS.
REQ-022 The granted index SHALL be latched as req.
REQ-023 Per-requester priority: dWEN goes to WB, else dREN goes to SNOOP, else cctrans goes to INV.
REQ-024 SNOOP (exactly 1 cycle): every i!=req gets ccwait=1 and ccsnoopaddr=daddr[req]; ccinv=1 for them if cctrans[req].
REQ-025 At the end of SNOOP, if any i!=req has ccwrite=1, the lowest such index is latched as resp and the FSM goes to XFER; else MEMRD.
REQ-026 XFER: dload[req]=dstore[resp]; ramWEN=1; ramstore=dstore[resp]; ramaddr=daddr[req]; dwait[req]=dwait[resp]=ramwait; ccwait=1 for all i!=req.
REQ-027 MEMRD: ramREN=1; ramaddr=daddr[req]; dload[req]=ramload; dwait[req]=ramwait.
REQ-028 WB: ramWEN=1; ramaddr=daddr[req]; ramstore=dstore[req]; dwait[req]=ramwait; no snoop.
REQ-029 In XFER/MEMRD/WB, each cycle with ramwait=0 increments word counter wcnt.
REQ-030 When wcnt==BLOCK_WORDS-1 and ramwait=0: return to IDLE, clear wcnt, set rr_ptr=(req+1) mod CPUS.
REQ-031 INV (1 cycle): ccwait=ccinv=1 and ccsnoopaddr=daddr[req] to all i!=req; dwait[req]=0; then IDLE with rr_ptr advanced.
REQ-032 Latency: granted in cycle 0, SNOOP in cycle 1, first RAM access in cycle 2; WB accesses RAM in cycle 1.
REQ-033 ramREN and ramWEN SHALL never both be 1; both are 0 in IDLE/SNOOP/INV.
REQ-034 dwait=1 for every cache except where REQ-026..031 drive it; dload=0 for non-targets.
REQ-035 ccwrite[req], and requests arriving mid-transaction, SHALL be ignored until the next IDLE.
REQ-036 Deasserting a request mid-transaction does not abort it; the block completes.
REQ-037 CPUS=1: SNOOP drives no snoop outputs and always exits to MEMRD.

Reset
REQ-038 nRST low asynchronously forces: state=IDLE, rr_ptr=0, wcnt=0, req=resp=0.
REQ-039 During reset: all dwait=1, ccwait=ccinv=0, ramREN=ramWEN=0, dload=ramstore=0, ramaddr=0, ccsnoopaddr=0.
REQ-040 Reset mid-transaction discards it with no further RAM access.

Verification
REQ-041 CPUS=2: dREN[0], no ccwrite, ramwait 0 -> SNOOP, then 2 MEMRD cycles with dwait[0]=0 and ramREN=1, then IDLE.
REQ-042 dREN[1]=1 with cctrans[1]=1; ccwrite[0]=1, dstore[0]=0xCAFE -> ccinv[0]=1 in SNOOP; XFER dload[1]=0xCAFE and ramstore=0xCAFE with ramWEN=1.
REQ-043 dREN[0]=dREN[1]=1 held, rr_ptr=0 -> cache 0 served first, cache 1 second, then cache 0.
REQ-044 cctrans[0] only -> one INV cycle with ccinv[1]=ccwait[1]=1 and dwait[0]=0, ramREN=ramWEN=0.
REQ-045 dWEN[1], ramwait high 3 cycles per word -> dwait[1] high during the stalls; 2 words written; no ccwait asserted.
REQ-046 nRST low during the second MEMRD word -> all outputs at reset values immediately; the next request is granted from rr_ptr=0.
